xcvr_reconfig_master: RTL
=========================

# xcvr_reconfig_master

Avalon-MM master that drives the transceiver test system's 32-bit bridge slave (15-bit word address, single-beat, pipelined reads) from a simple command/response stream. Executes single write, single read, read-modify-write and poll-until-match operations against transceiver/PLL reconfiguration registers, with per-access timeout. Sits directly upstream of the bridge in the 100 MHz domain; the command source is the host-link decoder.

## Interface
Parameters:
- ADDR_W, 15, Avalon word-address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 65535, max cycles per bus access (request+response) before abort
- POLL_MAX, 1023, max reads in a poll op before failure

Ports:
- clk_100_clk  in  1  clock; single clock domain
- reset_100_reset_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0 WRITE, 1 READ, 2 RMW, 3 POLL
- cmd_addr  in  ADDR_W  word address
- cmd_data  in  DATA_W  write data / RMW insert value / poll compare value
- cmd_mask  in  DATA_W  RMW/POLL bit mask (ignored for WRITE/READ)
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  result word
- rsp_status  out  2  0 OK, 1 TIMEOUT, 2 POLL_FAIL
- avm_address  out  ADDR_W
- avm_read, avm_write  out  1
- avm_writedata  out  DATA_W
- avm_byteenable  out  4  constant 4'hF
- avm_burstcount  out  1  constant 1
- avm_debugaccess  out  1  constant 0
- avm_waitrequest  in  1
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RSP.
- IDLE: cmd_ready=1. On accept latch op/addr/data/mask, clear poll count; WRITE -> WR_REQ, else -> RD_REQ.
- RD_REQ: avm_read=1 held until cycle with !avm_waitrequest -> RD_WAIT.
- RD_WAIT: on avm_readdatavalid capture readdata into rd_q:
  - READ: rsp_data=rd_q, OK -> RSP.
  - RMW: wr_q=(rd_q & ~mask)|(data & mask) -> WR_REQ.
  - POLL: if (rd_q & mask)==(data & mask) -> RSP OK; else if poll count==POLL_MAX-1 -> RSP POLL_FAIL; else count+1 -> RD_REQ. rsp_data=last rd_q.
- WR_REQ: avm_write=1, writedata=cmd_data (WRITE) or wr_q (RMW), held until !avm_waitrequest -> RSP OK; rsp_data=value written.
- Timeout: counter cleared on entry to RD_REQ and WR_REQ, counts every cycle in RD_REQ/RD_WAIT/WR_REQ; reaching TIMEOUT_CYCLES drops avm_read/avm_write, -> RSP TIMEOUT, rsp_data=0.
- RSP: rsp_valid=1, data/status stable until rsp_ready -> IDLE.
- avm_readdatavalid outside RD_WAIT is discarded (late data after timeout).
- Address/writedata stable while strobe asserted.

## Timing
- Reset: state IDLE; avm_read, avm_write, rsp_valid, rsp_status, rsp_data, avm_address, avm_writedata, counters = 0; cmd_ready=0 while reset_n low, 1 the first cycle after in IDLE.
- Zero-wait slave, readdatavalid one cycle after accept; cmd accepted cycle 0:
  - WRITE: avm_write cycle 1, rsp_valid cycle 2.
  - READ: avm_read cycle 1, readdatavalid cycle 2, rsp_valid cycle 3.
  - RMW: read cycle 1, rdv cycle 2, write cycle 3, rsp_valid cycle 4.
  - POLL: each miss adds 2 cycles (new read cycle after rdv).
- Back-to-back: next command accepted the cycle after rsp handshake (cmd_ready only in IDLE).
- Reset mid-operation: strobes and rsp_valid low at next edge; in-flight access abandoned.

## Structure
- Package xcvr_reconfig_pkg: op codes, status codes, state enum, ADDR_W/DATA_W defaults.
- Single module, no sub-modules; timeout and poll counters inline.

## Test plan
- WRITE addr 0x0100 data 0xDEADBEEF, waitrequest high 3 cycles -> avm_write held 4 cycles, addr/data stable, rsp OK data 0xDEADBEEF.
- READ addr 0x7FFF, slave returns 0x12345678 after 5 cycles latency -> rsp_data 0x12345678, OK, one avm_read accept.
- RMW addr 0x0010, slave reads 0xFFFF0000, mask 0x000000FF, data 0x000000A5 -> write 0xFFFF00A5, rsp_data 0xFFFF00A5.
- POLL mask 0x1, data 0x1, slave returns 0,0,1 -> three reads, rsp OK data 0x1; with POLL_MAX=4 and always 0 -> four reads, POLL_FAIL.
- waitrequest stuck high, TIMEOUT_CYCLES=16 -> avm_read drops after 16 cycles, rsp TIMEOUT; stray readdatavalid later ignored, next READ returns correct data.
- Reset asserted during RD_WAIT with rsp_ready low -> all outputs 0 next cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/xcvr_reconfig_pkg.sv
// Shared op codes, status codes and FSM state encodings
// for the transceiver reconfiguration Avalon-MM master.
package xcvr_reconfig_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;
    localparam logic [1:0] OP_POLL  = 2'd3;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_TIMEOUT   = 2'd1;
    localparam logic [1:0] ST_POLL_FAIL = 2'd2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RD_REQ = 3'd1;
    localparam state_t S_RD_WAIT = 3'd2;
    localparam state_t S_WR_REQ = 3'd3;
    localparam state_t S_RSP    = 3'd4;

endpackage

// File: rtl/xcvr_reconfig_master_if.sv
// Command/response stream plus Avalon-MM master bus bundle.
// master = the reconfig engine, slave = host decoder + bridge side.
interface xcvr_reconfig_master_if
    import xcvr_reconfig_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_burstcount;
    logic              avm_debugaccess;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  rsp_ready,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_status,
        output avm_address, avm_read, avm_write, avm_writedata,
        output avm_byteenable, avm_burstcount, avm_debugaccess
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output rsp_ready,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_status,
        input  avm_address, avm_read, avm_write, avm_writedata,
        input  avm_byteenable, avm_burstcount, avm_debugaccess
    );

endinterface

// File: rtl/xcvr_reconfig_master.sv
// Avalon-MM master running write/read/RMW/poll ops on the
// transceiver reconfig bridge, with per-access timeout.
module xcvr_reconfig_master
    import xcvr_reconfig_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int POLL_MAX       = 1023
) (
    input logic                    clk_100_clk,
    input logic                    reset_100_reset_n,
    xcvr_reconfig_master_if.master bus
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int POLL_W = $clog2(POLL_MAX + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_status;
    logic [TMO_W-1:0]  r_tmo;
    logic [POLL_W-1:0] r_poll;

    logic              w_tmo_hit;
    logic              w_match;
    logic [DATA_W-1:0] w_rmw;

    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_match   = ((bus.avm_readdata ^ r_data) & r_mask) == '0;
    assign w_rmw     = (bus.avm_readdata & ~r_mask) | (r_data & r_mask);

    assign bus.cmd_ready       = reset_100_reset_n && (r_state == S_IDLE);
    assign bus.rsp_valid       = (r_state == S_RSP);
    assign bus.rsp_data        = r_rsp_data;
    assign bus.rsp_status      = r_rsp_status;
    assign bus.avm_read        = (r_state == S_RD_REQ);
    assign bus.avm_write       = (r_state == S_WR_REQ);
    assign bus.avm_address     = r_addr;
    assign bus.avm_writedata   = r_wdata;
    assign bus.avm_byteenable  = 4'hF;
    assign bus.avm_burstcount  = 1'b1;
    assign bus.avm_debugaccess = 1'b0;

    always_ff @(posedge clk_100_clk) begin
        if (!reset_100_reset_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_WRITE;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_wdata      <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
            r_tmo        <= '0;
            r_poll       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op    <= bus.cmd_op;
                        r_addr  <= bus.cmd_addr;
                        r_data  <= bus.cmd_data;
                        r_mask  <= bus.cmd_mask;
                        r_wdata <= bus.cmd_data;
                        r_poll  <= '0;
                        r_tmo   <= '0;
                        r_state <= (bus.cmd_op == OP_WRITE) ? S_WR_REQ : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (!bus.avm_waitrequest) begin
                        r_state <= S_RD_WAIT;
                    end else if (w_tmo_hit) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_TIMEOUT;
                        r_state      <= S_RSP;
                    end
                end
                S_RD_WAIT: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (bus.avm_readdatavalid) begin
                        case (r_op)
                            OP_RMW: begin
                                r_wdata <= w_rmw;
                                r_tmo   <= '0;
                                r_state <= S_WR_REQ;
                            end
                            OP_POLL: begin
                                r_rsp_data <= bus.avm_readdata;
                                if (w_match) begin
                                    r_rsp_status <= ST_OK;
                                    r_state      <= S_RSP;
                                end else if (r_poll == POLL_LAST) begin
                                    r_rsp_status <= ST_POLL_FAIL;
                                    r_state      <= S_RSP;
                                end else begin
                                    r_poll  <= r_poll + POLL_W'(1);
                                    r_tmo   <= '0;
                                    r_state <= S_RD_REQ;
                                end
                            end
                            default: begin
                                r_rsp_data   <= bus.avm_readdata;
                                r_rsp_status <= ST_OK;
                                r_state      <= S_RSP;
                            end
                        endcase
                    end else if (w_tmo_hit) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_TIMEOUT;
                        r_state      <= S_RSP;
                    end
                end
                S_WR_REQ: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (!bus.avm_waitrequest) begin
                        r_rsp_data   <= r_wdata;
                        r_rsp_status <= ST_OK;
                        r_state      <= S_RSP;
                    end else if (w_tmo_hit) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_TIMEOUT;
                        r_state      <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
